// File: rtl/mdio_phy_poll.sv
// Periodic PHY status poller over an MDIO request/response driver.
// Also issues a PHY soft reset on a debounced push-button press.
module mdio_phy_poll #(
   parameter logic [23:0] TIME_CNT  = 24'd5_000_000,
   parameter logic [19:0] DEB_CNT   = 20'd500_000,
   parameter logic [3:0]  RST_TRIES = 4'd8
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        key,
   output logic        op_exec,
   output logic        op_rh_wl,
   output logic [4:0]  op_addr,
   output logic [15:0] op_wr_data,
   input  logic        op_done,
   input  logic [15:0] op_rd_data,
   input  logic        op_rd_ack,
   output logic        link,
   output logic [1:0]  speed,
   output logic        phy_err,
   output logic [1:0]  led
);

   localparam logic [4:0]  REG_BMCR  = 5'h00;
   localparam logic [4:0]  REG_BMSR  = 5'h01;
   localparam logic [4:0]  REG_PHYSR = 5'h11;
   localparam logic [15:0] BMCR_RST  = 16'h9140;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RST_WR,
      S_RST_WR_W,
      S_RST_RD,
      S_RST_RD_W,
      S_BMSR,
      S_BMSR_W,
      S_PHYSR,
      S_PHYSR_W
   } state_t;

   state_t      r_state;
   logic [23:0] r_idle_cnt;
   logic [3:0]  r_try;
   logic        r_pend;
   logic        r_key_s1;
   logic        r_key_s2;
   logic [19:0] r_deb_cnt;
   logic        r_deb_done;
   logic        r_op_exec;
   logic        r_op_rh_wl;
   logic [4:0]  r_op_addr;
   logic [15:0] r_op_wr_data;
   logic        r_link;
   logic [1:0]  r_speed;
   logic        r_phy_err;
   logic [1:0]  r_led;
   logic        w_press;
   logic        w_unused;

   assign op_exec    = r_op_exec;
   assign op_rh_wl   = r_op_rh_wl;
   assign op_addr    = r_op_addr;
   assign op_wr_data = r_op_wr_data;
   assign link       = r_link;
   assign speed      = r_speed;
   assign phy_err    = r_phy_err;
   assign led        = r_led;

   // Only status bits 15, 14 and 2 carry meaning for this poller.
   assign w_unused = ^{op_rd_data[13:3], op_rd_data[1:0]};

   // One accepted press per stable high level of the synchronised key.
   assign w_press = r_key_s2 & ~r_deb_done &
                    (r_deb_cnt == DEB_CNT - 20'd1);

   // Key synchroniser and debounce counter (saturates, never wraps).
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_key_s1   <= 1'b0;
         r_key_s2   <= 1'b0;
         r_deb_cnt  <= '0;
         r_deb_done <= 1'b0;
      end else begin
         r_key_s1 <= key;
         r_key_s2 <= r_key_s1;
         if (!r_key_s2) begin
            r_deb_cnt  <= '0;
            r_deb_done <= 1'b0;
         end else if (w_press) begin
            r_deb_done <= 1'b1;
         end else if (!r_deb_done) begin
            r_deb_cnt <= r_deb_cnt + 20'd1;
         end
      end
   end

   // Poll / soft-reset sequencer with registered request and status outputs.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_state      <= S_IDLE;
         r_idle_cnt   <= '0;
         r_try        <= '0;
         r_pend       <= 1'b0;
         r_op_exec    <= 1'b0;
         r_op_rh_wl   <= 1'b1;
         r_op_addr    <= '0;
         r_op_wr_data <= '0;
         r_link       <= 1'b0;
         r_speed      <= 2'b11;
         r_phy_err    <= 1'b0;
      end else begin
         r_op_exec <= 1'b0;
         if (w_press && r_state != S_IDLE)
            r_pend <= 1'b1;
         unique case (r_state)
            S_IDLE: begin
               if (r_pend || w_press) begin
                  r_pend       <= 1'b0;
                  r_idle_cnt   <= '0;
                  r_try        <= '0;
                  r_state      <= S_RST_WR;
                  r_op_exec    <= 1'b1;
                  r_op_rh_wl   <= 1'b0;
                  r_op_addr    <= REG_BMCR;
                  r_op_wr_data <= BMCR_RST;
               end else if (r_idle_cnt == TIME_CNT - 24'd1) begin
                  r_idle_cnt <= '0;
                  r_state    <= S_BMSR;
                  r_op_exec  <= 1'b1;
                  r_op_rh_wl <= 1'b1;
                  r_op_addr  <= REG_BMSR;
               end else begin
                  r_idle_cnt <= r_idle_cnt + 24'd1;
               end
            end
            S_RST_WR: r_state <= S_RST_WR_W;
            S_RST_RD: r_state <= S_RST_RD_W;
            S_BMSR:   r_state <= S_BMSR_W;
            S_PHYSR:  r_state <= S_PHYSR_W;
            S_RST_WR_W, S_RST_RD_W, S_BMSR_W, S_PHYSR_W: begin
               if (op_done && !op_rd_ack) begin
                  r_phy_err <= 1'b1;
                  r_link    <= 1'b0;
                  r_speed   <= 2'b11;
                  r_state   <= S_IDLE;
               end else if (op_done) begin
                  if (r_state == S_RST_WR_W) begin
                     r_state    <= S_RST_RD;
                     r_op_exec  <= 1'b1;
                     r_op_rh_wl <= 1'b1;
                     r_op_addr  <= REG_BMCR;
                  end else if (r_state == S_RST_RD_W) begin
                     if (!op_rd_data[15]) begin
                        r_state    <= S_BMSR;
                        r_op_exec  <= 1'b1;
                        r_op_rh_wl <= 1'b1;
                        r_op_addr  <= REG_BMSR;
                     end else if (r_try == RST_TRIES - 4'd1) begin
                        r_phy_err <= 1'b1;
                        r_state   <= S_IDLE;
                     end else begin
                        r_try      <= r_try + 4'd1;
                        r_state    <= S_RST_RD;
                        r_op_exec  <= 1'b1;
                        r_op_rh_wl <= 1'b1;
                        r_op_addr  <= REG_BMCR;
                     end
                  end else if (r_state == S_BMSR_W) begin
                     if (op_rd_data[2]) begin
                        r_state    <= S_PHYSR;
                        r_op_exec  <= 1'b1;
                        r_op_rh_wl <= 1'b1;
                        r_op_addr  <= REG_PHYSR;
                     end else begin
                        r_link    <= 1'b0;
                        r_speed   <= 2'b11;
                        r_phy_err <= 1'b0;
                        r_state   <= S_IDLE;
                     end
                  end else begin
                     r_link    <= 1'b1;
                     r_speed   <= op_rd_data[15:14];
                     r_phy_err <= 1'b0;
                     r_state   <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // LEDs follow the status registers one cycle later.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n)
         r_led <= 2'b00;
      else
         r_led <= {r_link & (r_speed == 2'b10), r_link};
   end

endmodule

// File: tb/tb_mdio_phy_poll.sv
// Directed bench for mdio_phy_poll with a 20-cycle MDIO driver model.
// Table of poll outcomes plus hand sequences for reset and key handling.
module tb_mdio_phy_poll;

   logic        sys_clk;
   logic        sys_rst_n;
   logic        key;
   logic        op_exec;
   logic        op_rh_wl;
   logic [4:0]  op_addr;
   logic [15:0] op_wr_data;
   logic        op_done;
   logic [15:0] op_rd_data;
   logic        op_rd_ack;
   logic        link;
   logic [1:0]  speed;
   logic        phy_err;
   logic [1:0]  led;

   mdio_phy_poll #(
      .TIME_CNT  (24'd1000),
      .DEB_CNT   (20'd10),
      .RST_TRIES (4'd8)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .key        (key),
      .op_exec    (op_exec),
      .op_rh_wl   (op_rh_wl),
      .op_addr    (op_addr),
      .op_wr_data (op_wr_data),
      .op_done    (op_done),
      .op_rd_data (op_rd_data),
      .op_rd_ack  (op_rd_ack),
      .link       (link),
      .speed      (speed),
      .phy_err    (phy_err),
      .led        (led)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int n_tests = 0;
   int n_fail  = 0;

   // PHY register model and driver log
   logic [15:0] reg0_val;
   logic [15:0] bmsr_val;
   logic [15:0] physr_val;
   logic        nack_bmsr;
   logic [4:0]  log_addr [64];
   logic        log_rh   [64];
   logic [15:0] log_wd   [64];
   int          n_ops   = 0;
   int          overlap = 0;

   typedef struct {
      logic [15:0] bmsr;
      logic [15:0] physr;
      logic        nack;
      logic        e_link;
      logic [1:0]  e_speed;
      logic [1:0]  e_led;
      logic        e_err;
      int          e_nops;
      logic [4:0]  e_last;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_exec(output int cyc);
      cyc = 0;
      do begin
         @(posedge sys_clk);
         #1;
         cyc++;
      end while (op_exec !== 1'b1 && cyc < 2000);
      if (op_exec !== 1'b1)
         chk("exec_timeout", {31'd0, op_exec}, 32'd1);
   endtask

   task automatic press_key();
      key = 1'b1;
      repeat (15) @(posedge sys_clk);
      #1;
      key = 1'b0;
   endtask

   // Driver model: op_done 20 cycles after op_exec, data from the model.
   initial begin
      int          cd;
      logic [4:0]  cur;
      cd = 0;
      cur = '0;
      op_done    = 1'b0;
      op_rd_data = '0;
      op_rd_ack  = 1'b1;
      forever begin
         @(posedge sys_clk);
         #1;
         op_done = 1'b0;
         if (op_exec === 1'b1 && cd > 0)
            overlap++;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               op_done    = 1'b1;
               op_rd_ack  = !(nack_bmsr && cur == 5'h01);
               op_rd_data = (cur == 5'h00) ? reg0_val :
                            (cur == 5'h01) ? bmsr_val :
                            (cur == 5'h11) ? physr_val : 16'h0;
            end
         end
         if (op_exec === 1'b1) begin
            cur = op_addr;
            if (n_ops < 64) begin
               log_addr[n_ops] = op_addr;
               log_rh[n_ops]   = op_rh_wl;
               log_wd[n_ops]   = op_wr_data;
            end
            n_ops++;
            cd = 19;
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc;
      int base;
      int nrd;
      int nbm;
      vecs[0] = '{16'h796D, 16'h8000, 1'b0, 1'b1, 2'b10, 2'b11, 1'b0, 2, 5'h11};
      vecs[1] = '{16'h7969, 16'h8000, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1, 5'h01};
      vecs[2] = '{16'h796D, 16'h4000, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 2, 5'h11};
      vecs[3] = '{16'h796D, 16'hC000, 1'b0, 1'b1, 2'b11, 2'b01, 1'b0, 2, 5'h11};
      vecs[4] = '{16'h796D, 16'h0000, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 2, 5'h11};
      vecs[5] = '{16'h796D, 16'h8000, 1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 1, 5'h01};
      vecs[6] = '{16'h796D, 16'h8000, 1'b0, 1'b1, 2'b10, 2'b11, 1'b0, 2, 5'h11};

      key       = 1'b0;
      sys_rst_n = 1'b0;
      reg0_val  = 16'h1140;
      bmsr_val  = vecs[0].bmsr;
      physr_val = vecs[0].physr;
      nack_bmsr = 1'b0;

      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_exec",  {31'd0, op_exec}, 32'd0);
      chk("rst_rh",    {31'd0, op_rh_wl}, 32'd1);
      chk("rst_addr",  {27'd0, op_addr}, 32'd0);
      chk("rst_wd",    {16'd0, op_wr_data}, 32'd0);
      chk("rst_link",  {31'd0, link}, 32'd0);
      chk("rst_speed", {30'd0, speed}, 32'd3);
      chk("rst_err",   {31'd0, phy_err}, 32'd0);
      chk("rst_led",   {30'd0, led}, 32'd0);
      sys_rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         bmsr_val  = vecs[i].bmsr;
         physr_val = vecs[i].physr;
         nack_bmsr = vecs[i].nack;
         base = n_ops;
         wait_exec(cyc);
         if (i == 0) begin
            chk("first_exec_latency", cyc, 32'd1000);
            chk("first_exec_addr", {27'd0, op_addr}, 32'd1);
            chk("first_exec_rh", {31'd0, op_rh_wl}, 32'd1);
         end
         repeat (60) @(posedge sys_clk);
         #1;
         chk($sformatf("v%0d_link", i), {31'd0, link}, {31'd0, vecs[i].e_link});
         chk($sformatf("v%0d_speed", i), {30'd0, speed}, {30'd0, vecs[i].e_speed});
         chk($sformatf("v%0d_led", i), {30'd0, led}, {30'd0, vecs[i].e_led});
         chk($sformatf("v%0d_err", i), {31'd0, phy_err}, {31'd0, vecs[i].e_err});
         chk($sformatf("v%0d_nops", i), n_ops - base, vecs[i].e_nops);
         chk($sformatf("v%0d_last_addr", i), {27'd0, log_addr[n_ops-1]},
             {27'd0, vecs[i].e_last});
      end
      nack_bmsr = 1'b0;

      // Key pressed during BMSR read: reset follows the completed poll.
      reg0_val = 16'h1140;
      base = n_ops;
      wait_exec(cyc);
      press_key();
      repeat (200) @(posedge sys_clk);
      #1;
      chk("key_nops", n_ops - base, 32'd6);
      chk("key_op0_addr", {27'd0, log_addr[base]}, 32'h01);
      chk("key_op1_addr", {27'd0, log_addr[base+1]}, 32'h11);
      chk("key_wr_addr", {27'd0, log_addr[base+2]}, 32'h00);
      chk("key_wr_rh", {31'd0, log_rh[base+2]}, 32'd0);
      chk("key_wr_data", {16'd0, log_wd[base+2]}, 32'h9140);
      chk("key_rd0_addr", {27'd0, log_addr[base+3]}, 32'h00);
      chk("key_rd0_rh", {31'd0, log_rh[base+3]}, 32'd1);
      chk("key_bmsr_addr", {27'd0, log_addr[base+4]}, 32'h01);
      chk("key_physr_addr", {27'd0, log_addr[base+5]}, 32'h11);
      chk("key_link", {31'd0, link}, 32'd1);
      chk("key_err", {31'd0, phy_err}, 32'd0);

      // Soft reset never clears: eight reg0 reads then phy_err.
      reg0_val = 16'h9140;
      base = n_ops;
      press_key();
      repeat (300) @(posedge sys_clk);
      #1;
      nrd = 0;
      nbm = 0;
      for (int j = base; j < n_ops && j < 64; j++) begin
         if (log_addr[j] == 5'h00 && log_rh[j]) nrd++;
         if (log_addr[j] == 5'h01) nbm++;
      end
      chk("stuck_nops", n_ops - base, 32'd9);
      chk("stuck_reg0_reads", nrd, 32'd8);
      chk("stuck_no_bmsr", nbm, 32'd0);
      chk("stuck_err", {31'd0, phy_err}, 32'd1);

      reg0_val = 16'h1140;
      base = n_ops;
      wait_exec(cyc);
      chk("recover_addr", {27'd0, op_addr}, 32'h01);
      repeat (60) @(posedge sys_clk);
      #1;
      chk("recover_nops", n_ops - base, 32'd2);
      chk("recover_err", {31'd0, phy_err}, 32'd0);
      chk("recover_link", {31'd0, link}, 32'd1);

      // One-cycle reset in the middle of a BMSR read.
      wait_exec(cyc);
      repeat (5) @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b0;
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      chk("mid_rst_exec",  {31'd0, op_exec}, 32'd0);
      chk("mid_rst_rh",    {31'd0, op_rh_wl}, 32'd1);
      chk("mid_rst_addr",  {27'd0, op_addr}, 32'd0);
      chk("mid_rst_wd",    {16'd0, op_wr_data}, 32'd0);
      chk("mid_rst_link",  {31'd0, link}, 32'd0);
      chk("mid_rst_speed", {30'd0, speed}, 32'd3);
      chk("mid_rst_err",   {31'd0, phy_err}, 32'd0);
      chk("mid_rst_led",   {30'd0, led}, 32'd0);
      base = n_ops;
      wait_exec(cyc);
      chk("mid_rst_latency", cyc, 32'd1000);
      chk("mid_rst_late_link", {31'd0, link}, 32'd0);
      chk("mid_rst_late_speed", {30'd0, speed}, 32'd3);
      repeat (2) @(posedge sys_clk);
      #1;
      chk("mid_rst_nops", n_ops - base, 32'd1);

      chk("exec_overlap", overlap, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mdio_phy_poll.md
MDIO_PHY_POLL -- requirements
Module: mdio_phy_poll

Interface
REQ-001 SHALL have parameter TIME_CNT, default 24'd5_000_000: idle interval in sys_clk cycles between status polls.
REQ-002 SHALL have parameter DEB_CNT, default 20'd500_000: key stable time in sys_clk cycles before a press is accepted.
REQ-003 SHALL have parameter RST_TRIES, default 4'd8: maximum reg0 re-reads while waiting for soft-reset clear.
REQ-004 SHALL have ports, clock and reset first:
- sys_clk in 1: single clock; all logic on rising edge.
- sys_rst_n in 1: reset, synchronous, active-low.
- key in 1: asynchronous push-button, active-high; requests PHY soft reset.
- op_exec out 1: one-cycle request pulse to the MDIO driver.
- op_rh_wl out 1: 1 = read, 0 = write; valid with op_exec, held until op_done.
- op_addr out 5: PHY register address; held until op_done.
- op_wr_data out 16: write data; held until op_done.
- op_done in 1: one-cycle completion pulse from the driver.
- op_rd_data in 16: read data; valid while op_done = 1.
- op_rd_ack in 1: 1 = PHY drove ACK low; valid while op_done = 1.
- link out 1: PHY link up.
- speed out 2: 00 = 10M, 01 = 100M, 10 = 1000M, 11 = reserved/unknown.
- phy_err out 1: last sequence saw a missing ACK or a soft-reset timeout.
- led out 2: led[0] = link, led[1] = link & (speed == 10).

Function
REQ-005 SHALL synchronise key through two flops, then debounce: an accepted press needs the synchronised level to stay 1 for DEB_CNT consecutive cycles; one accepted press per 0->1 level change.
REQ-006 SHALL run the FSM IDLE, RST_WR, RST_RD, RD_BMSR, RD_PHYSR, with one wait-for-done substate per issuing state.
REQ-007 IDLE SHALL count 0..TIME_CNT-1 and move to RD_BMSR when the count ends; a pending reset request instead moves it to RST_WR immediately and clears the counter.
REQ-008 RST_WR SHALL issue a write to reg 0x00 with data 16'h9140; on op_done it goes to RST_RD.
REQ-009 RST_RD SHALL read reg 0x00: bit15 = 0 with ACK goes to RD_BMSR. Bit15 = 1 re-reads. After RST_TRIES reads without clear, it sets phy_err and goes to IDLE.
REQ-010 RD_BMSR SHALL read reg 0x01: bit2 = 1 goes to RD_PHYSR. Bit2 = 0 sets link = 0, speed = 2'b11, and goes to IDLE.
REQ-011 RD_PHYSR SHALL read reg 0x11, then set link = 1 and speed = op_rd_data[15:14], and go to IDLE.
REQ-012 Any op_done with op_rd_ack = 0 SHALL abort the sequence: set phy_err = 1, link = 0, speed = 2'b11, and go to IDLE.
REQ-013 phy_err SHALL clear only when a full poll sequence (RD_BMSR onward) completes with all ACKs.
REQ-014 op_exec SHALL pulse exactly one cycle on entry to each issuing state. The next op_exec SHALL come no earlier than the cycle after op_done.
REQ-015 op_done while no request is outstanding SHALL be ignored.
REQ-016 A key press accepted outside IDLE SHALL be latched as pending and served at the next IDLE entry.
REQ-017 A press accepted while a request is already pending SHALL merge into it; pending clears on entry to RST_WR.
REQ-018 link, speed and phy_err SHALL update in the cycle after the deciding op_done; led is registered from them, one further cycle.
REQ-019 The IDLE counter SHALL wrap to 0 on leaving IDLE; no other counter wraps.

Reset
REQ-020 While sys_rst_n = 0 at a clock edge the block SHALL hold: FSM = IDLE, all counters = 0, pending = 0, op_exec = 0, op_rh_wl = 1, op_addr = 0, op_wr_data = 0, link = 0, speed = 2'b11, phy_err = 0, led = 2'b00.
REQ-021 Reset asserted mid-transaction SHALL abandon it with no further op_exec; any op_done arriving after release SHALL be ignored.

Verification
REQ-022 Use TIME_CNT = 1000 and DEB_CNT = 10; the driver model replies with op_done 20 cycles after op_exec.
- After reset release -> the first op_exec comes 1000 cycles later: read, addr 0x01.
- BMSR = 16'h796D, PHYSR = 16'h8000 -> link = 1, speed = 10, led = 2'b11; reads go to 0x01 then 0x11.
- BMSR = 16'h7969 -> no 0x11 read; link = 0, speed = 11, led = 00.
- key high for 15 cycles during RD_BMSR -> write 0x00 = 16'h9140 issued right after the poll completes. Reg0 reads 16'h1140 -> BMSR read follows.
- Reg0 stuck at 16'h9140 -> exactly 8 reg0 reads, then phy_err = 1, and the next good poll clears it.
- op_rd_ack = 0 on BMSR -> phy_err = 1, link = 0.
- sys_rst_n low for 1 cycle mid-read -> all outputs at reset values; the late op_done is ignored.
